// File: rtl/decoder_3x8.sv
// Registered 3-to-8 line decoder with enable and selectable output polarity.
// The select {a,b,c} picks the single active line of y; valid tracks a sampled en=1.
module decoder_3x8 #(
   parameter bit ACTIVE_LOW = 1'b0,
   parameter bit REG_OUT    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   output logic [7:0] y,
   output logic       valid
);

   localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [2:0] sel;
   logic [7:0] onehot;
   logic [7:0] y_d;
   logic       valid_d;
   logic       valid_q;

   assign sel = {a, b, c};

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_line
         assign onehot[gi] = en && (sel == 3'(gi));
      end
   endgenerate

   // Polarity is applied after gating so en=0 lands on the inactive pattern.
   always_comb begin
      y_d     = onehot ^ {8{ACTIVE_LOW}};
      valid_d = en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign valid = valid_q;

   generate
      if (REG_OUT) begin : g_reg
         logic [7:0] y_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               y_q <= INACTIVE;
            end else begin
               y_q <= y_d;
            end
         end

         assign y = y_q;
      end else begin : g_comb
         // Reset still overrides the combinational path so y clears at once.
         assign y = rst ? INACTIVE : y_d;
      end
   endgenerate

endmodule

// File: tb/tb_decoder_3x8.sv
// Directed bench for decoder_3x8: three builds (active-high registered,
// active-low registered, active-high combinational) share one stimulus.
module tb_decoder_3x8;

   logic       clk;
   logic       rst;
   logic       en;
   logic       a;
   logic       b;
   logic       c;
   logic [7:0] y0, y1, y2;
   logic       v0, v1, v2;

   int total = 0;
   int bad   = 0;

   decoder_3x8 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) u_hi (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .y(y0), .valid(v0));
   decoder_3x8 #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) u_lo (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .y(y1), .valid(v1));
   decoder_3x8 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) u_cb (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .y(y2), .valid(v2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [2:0] sel;
      logic [7:0] ey_hi;
      logic [7:0] ey_lo;
      logic       ev;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [2:0] s);
      en = e;
      {a, b, c} = s;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 3'd0, 8'h01, 8'hFE, 1'b1};
      vecs[1]  = '{1'b1, 3'd1, 8'h02, 8'hFD, 1'b1};
      vecs[2]  = '{1'b1, 3'd2, 8'h04, 8'hFB, 1'b1};
      vecs[3]  = '{1'b1, 3'd3, 8'h08, 8'hF7, 1'b1};
      vecs[4]  = '{1'b1, 3'd4, 8'h10, 8'hEF, 1'b1};
      vecs[5]  = '{1'b1, 3'd5, 8'h20, 8'hDF, 1'b1};
      vecs[6]  = '{1'b1, 3'd6, 8'h40, 8'hBF, 1'b1};
      vecs[7]  = '{1'b1, 3'd7, 8'h80, 8'h7F, 1'b1};
      vecs[8]  = '{1'b1, 3'd3, 8'h08, 8'hF7, 1'b1};
      vecs[9]  = '{1'b0, 3'd3, 8'h00, 8'hFF, 1'b0};
      vecs[10] = '{1'b1, 3'd3, 8'h08, 8'hF7, 1'b1};
      vecs[11] = '{1'b1, 3'd0, 8'h01, 8'hFE, 1'b1};
      vecs[12] = '{1'b1, 3'd7, 8'h80, 8'h7F, 1'b1};
      vecs[13] = '{1'b0, 3'd7, 8'h00, 8'hFF, 1'b0};
      vecs[14] = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b0};
      vecs[15] = '{1'b1, 3'd5, 8'h20, 8'hDF, 1'b1};

      // Reset held with en=1, abc=101: outputs inactive with no clock needed.
      rst = 1'b1;
      drive(1'b1, 3'b101);
      #1;
      chk("rst_y_hi", y0, 8'h00);
      chk("rst_y_lo", y1, 8'hFF);
      chk("rst_y_cb", y2, 8'h00);
      chk("rst_valid", {5'd0, v0, v1, v2}, 8'h00);
      step;
      step;
      chk("rst_hold_y_hi", y0, 8'h00);
      chk("rst_hold_y_lo", y1, 8'hFF);
      chk("rst_hold_valid", {5'd0, v0, v1, v2}, 8'h00);
      $display("txn reset hold: y_hi=%h y_lo=%h y_cb=%h", y0, y1, y2);
      #3;
      rst = 1'b0;
      step;
      chk("rel_y_hi", y0, 8'h20);
      chk("rel_y_lo", y1, 8'hDF);
      chk("rel_y_cb", y2, 8'h20);
      chk("rel_valid", {5'd0, v0, v1, v2}, 8'h07);
      $display("txn reset release: y_hi=%h y_lo=%h valid=%b", y0, y1, v0);

      // Table: sweep, enable gating, active-low patterns.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].en, vecs[i].sel);
         #1;
         chk($sformatf("v%0d_y_cb", i), y2, vecs[i].ey_hi);
         step;
         chk($sformatf("v%0d_y_hi", i), y0, vecs[i].ey_hi);
         chk($sformatf("v%0d_y_lo", i), y1, vecs[i].ey_lo);
         chk($sformatf("v%0d_valid", i), {5'd0, v0, v1, v2}, {5'd0, {3{vecs[i].ev}}});
         $display("txn vec %0d: en=%b sel=%0d y_hi=%h y_lo=%h y_cb=%h valid=%b",
                  i, vecs[i].en, vecs[i].sel, y0, y1, y2, v0);
      end

      // Mid-stream reset pulse shorter than a clock, abc=110.
      drive(1'b1, 3'b110);
      step;
      chk("mid_pre_y_hi", y0, 8'h40);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_y_hi", y0, 8'h00);
      chk("mid_rst_y_lo", y1, 8'hFF);
      chk("mid_rst_y_cb", y2, 8'h00);
      chk("mid_rst_valid", {5'd0, v0, v1, v2}, 8'h00);
      #1;
      rst = 1'b0;
      #1;
      chk("mid_norep_y_hi", y0, 8'h00);
      chk("mid_norep_y_cb", y2, 8'h40);
      chk("mid_norep_valid", {7'd0, v0}, 8'h00);
      step;
      chk("mid_post_y_hi", y0, 8'h40);
      chk("mid_post_y_lo", y1, 8'hBF);
      chk("mid_post_valid", {5'd0, v0, v1, v2}, 8'h07);
      $display("txn mid reset: y_hi=%h y_lo=%h valid=%b", y0, y1, v0);

      // Combinational build: select change between edges, valid timing.
      drive(1'b1, 3'b010);
      #1;
      chk("cb_sel2", y2, 8'h04);
      drive(1'b1, 3'b100);
      #1;
      chk("cb_sel4", y2, 8'h10);
      chk("cb_reg_unchanged", y0, 8'h40);
      drive(1'b0, 3'b100);
      #1;
      chk("cb_en0", y2, 8'h00);
      step;
      chk("cb_valid_low", {7'd0, v2}, 8'h00);
      drive(1'b1, 3'b100);
      #1;
      chk("cb_en1_y", y2, 8'h10);
      chk("cb_valid_not_yet", {7'd0, v2}, 8'h00);
      step;
      chk("cb_valid_rise", {7'd0, v2}, 8'h01);
      chk("cb_reg_y_hi", y0, 8'h10);
      $display("txn comb build: y_cb=%h valid_cb=%b", y2, v2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
